platform_scroller: RTL

//  Parametrised owner of the platform field. Replaces the fixed 15-pair platX/platY bus from jumplogic.

---
 rtl/platform_scroller_pkg.sv | 19 +
 rtl/platform_scroller_if.sv | 23 ++
 rtl/platform_scroller_lfsr16.sv | 19 +
 rtl/platform_scroller.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/platform_scroller_pkg.sv
// Shared types and defaults for the platform field: coordinate type, scroller states and the
// X-position selector used when a platform is (re)placed.
package platform_scroller_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned SCREEN_W_DEF = 640;
  localparam int unsigned SCREEN_H_DEF = 480;

  typedef enum logic [1:0] {INIT, IDLE, SCROLL} scroll_state_t;

  // Fold the low 10 LFSR bits into 0..xr-1; valid while 2*xr >= 1024.
  function automatic coord_t xsel(input logic [15:0] v, input coord_t xr);
    coord_t r;
    r = v[9:0];
    return (r < xr) ? r : r - xr;
  endfunction

endpackage

// File: rtl/platform_scroller_if.sv
// Scroll request and platform position bus between jumplogic (master) and the scroller (slave).
interface platform_scroller_if #(
  parameter int unsigned NUM_PLATS = 16
);
  logic                      frame_clk;
  logic                      scroll_en;
  logic [7:0]                scroll_amt;
  logic [10*NUM_PLATS-1:0]   plat_x;
  logic [10*NUM_PLATS-1:0]   plat_y;
  logic                      plat_valid;
  logic [15:0]               recycled;
  logic                      overrun;

  modport master (
    output frame_clk, scroll_en, scroll_amt,
    input  plat_x, plat_y, plat_valid, recycled, overrun
  );

  modport slave (
    input  frame_clk, scroll_en, scroll_amt,
    output plat_x, plat_y, plat_valid, recycled, overrun
  );
endinterface

// File: rtl/platform_scroller_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11); free-running, reloads the seed on Reset.
module lfsr16 (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  logic fb;

  assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q <= seed;
    end else begin
      q <= {q[14:0], fb};
    end
  end
endmodule

// File: rtl/platform_scroller.sv
// Owns the platform field: lays it out after reset, scrolls it once per frame edge and recycles
// platforms that fall off the bottom back to the top at a pseudo-random X.
module platform_scroller
  import platform_scroller_pkg::*;
#(
  parameter int unsigned NUM_PLATS = 16,
  parameter int unsigned SCREEN_W  = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H  = SCREEN_H_DEF,
  parameter int unsigned PLAT_W    = 64,
  parameter int unsigned SPACING   = 30,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                Clk,
  input  logic                Reset,
  platform_scroller_if.slave  bus
);

  localparam int unsigned     IdxW    = $clog2(NUM_PLATS);
  localparam int unsigned     XRange  = SCREEN_W - PLAT_W;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_PLATS - 1);

  if (NUM_PLATS < 2 || NUM_PLATS > 32 || SCREEN_H <= 255 || SCREEN_H > 1023 ||
      NUM_PLATS * SPACING > SCREEN_H || 2 * XRange < 1024 || XRange > 1023 ||
      LFSR_SEED == 16'h0000) begin : g_bad_params
    $error("platform_scroller: illegal parameter combination");
  end

  // frame_clk synchroniser and edge detect
  logic fc_s1, fc_s2, fc_s3;
  logic frame_tick;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fc_s1 <= 1'b0;
      fc_s2 <= 1'b0;
      fc_s3 <= 1'b0;
    end else begin
      fc_s1 <= bus.frame_clk;
      fc_s2 <= fc_s1;
      fc_s3 <= fc_s2;
    end
  end

  assign frame_tick = fc_s2 & ~fc_s3;

  logic [15:0] lfsr;

  lfsr16 u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .seed  (LFSR_SEED),
    .q     (lfsr)
  );

  scroll_state_t   state;
  logic [IdxW-1:0] idx;
  logic [7:0]      amt_q;
  logic [7:0]      pend_amt;
  logic            pending;
  logic            plat_valid_q;
  logic            overrun_q;
  logic [15:0]     recycled_q;
  coord_t          x_q [NUM_PLATS];
  coord_t          y_q [NUM_PLATS];

  coord_t      new_x;
  coord_t      init_y;
  logic [10:0] ny;
  logic        wrap;

  always_comb begin
    new_x  = xsel(lfsr, coord_t'(XRange));
    init_y = coord_t'(SCREEN_H - 1 - 32'(idx) * SPACING);
    ny     = {1'b0, y_q[idx]} + {3'b000, amt_q};
    wrap   = ny >= 11'(SCREEN_H);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= INIT;
      idx          <= '0;
      amt_q        <= '0;
      pend_amt     <= '0;
      pending      <= 1'b0;
      plat_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      recycled_q   <= '0;
      for (int i = 0; i < NUM_PLATS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      case (state)
        INIT: begin
          x_q[idx] <= new_x;
          y_q[idx] <= init_y;
          if (frame_tick) begin
            if (pending) begin
              overrun_q <= 1'b1;
            end else begin
              pending  <= 1'b1;
              pend_amt <= bus.scroll_amt;
            end
          end
          if (idx == LastIdx) begin
            idx          <= '0;
            state        <= IDLE;
            plat_valid_q <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        IDLE: begin
          // A tick captured while busy is served before any new request
          if (pending) begin
            amt_q        <= pend_amt;
            pending      <= frame_tick;
            if (frame_tick) pend_amt <= bus.scroll_amt;
            idx          <= '0;
            state        <= SCROLL;
            plat_valid_q <= 1'b0;
          end else if (frame_tick && bus.scroll_en && bus.scroll_amt != 8'd0) begin
            amt_q        <= bus.scroll_amt;
            idx          <= '0;
            state        <= SCROLL;
            plat_valid_q <= 1'b0;
          end
        end

        SCROLL: begin
          if (wrap) begin
            y_q[idx] <= coord_t'(ny - 11'(SCREEN_H));
            x_q[idx] <= new_x;
            if (recycled_q != 16'hFFFF) recycled_q <= recycled_q + 16'd1;
          end else begin
            y_q[idx] <= ny[9:0];
          end
          if (frame_tick) begin
            if (pending) begin
              overrun_q <= 1'b1;
            end else begin
              pending  <= 1'b1;
              pend_amt <= bus.scroll_amt;
            end
          end
          if (idx == LastIdx) begin
            idx <= '0;
            // Pending frame chains straight into another pass; a tick landing now waits in IDLE
            if (pending) begin
              pending <= 1'b0;
              amt_q   <= pend_amt;
            end else begin
              state        <= IDLE;
              plat_valid_q <= 1'b1;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end

        default: state <= INIT;
      endcase
    end
  end

  always_comb begin
    bus.plat_x = '0;
    bus.plat_y = '0;
    for (int i = 0; i < NUM_PLATS; i++) begin
      bus.plat_x[10*i +: 10] = x_q[i];
      bus.plat_y[10*i +: 10] = y_q[i];
    end
  end

  assign bus.plat_valid = plat_valid_q;
  assign bus.recycled   = recycled_q;
  assign bus.overrun    = overrun_q;

endmodule
